// File: rtl/video_filter_pipe.sv
// video_filter_pipe: RGB pixel pipeline with colour, gray, 3x3 Sobel and threshold modes.
// Fixed 3-cycle latency, two line buffers feed a 3x3 gray window for the gradient.
module video_filter_pipe #(
  parameter int IMG_W     = 320,
  parameter int IN_BITS   = 4,
  parameter int OUT_BITS  = 8,
  parameter int MAG_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eol,
  input  logic [3*IN_BITS-1:0] in_data,
  input  logic [1:0]           mode,
  input  logic [OUT_BITS-1:0]  thresh,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic [OUT_BITS-1:0]  out_r,
  output logic [OUT_BITS-1:0]  out_g,
  output logic [OUT_BITS-1:0]  out_b,
  output logic                 line_overflow
);
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int AW  = $clog2(IMG_W);
  localparam int SW  = OUT_BITS + 3;
  localparam int REP = OUT_BITS / IN_BITS + 1;
  localparam logic [10:0] ROW_MAX = '1;
  localparam logic [CW-1:0] COL_LIM = CW'(IMG_W);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [OUT_BITS-1:0] PIX_MAX = '1;

  typedef logic [OUT_BITS-1:0] pix_t;
  typedef logic signed [SW-1:0] sgn_t;

  function automatic pix_t expand(input logic [IN_BITS-1:0] c);
    logic [REP*IN_BITS-1:0] r;
    r = {REP{c}};
    return r[REP*IN_BITS-1 -: OUT_BITS];
  endfunction

  function automatic sgn_t sx(input pix_t p);
    return sgn_t'({3'b000, p});
  endfunction

  pix_t lb0 [IMG_W];
  pix_t lb1 [IMG_W];

  logic [CW-1:0] col_q, col_d, col_s;
  logic [10:0] row_q, row_d, row_s;
  logic [1:0] mode_q, mode_s;
  logic ovf_q, in_rng;
  logic [AW-1:0] addr;
  logic [OUT_BITS+1:0] ysum;
  pix_t r_s, g_s, b_s, y_s, rd0_s, rd1_s;

  // sof restarts the counters for its own pixel, not just the following one
  always_comb begin
    col_s  = in_sof ? '0 : col_q;
    row_s  = in_sof ? '0 : row_q;
    in_rng = col_s < COL_LIM;
    addr   = col_s[AW-1:0];
    r_s    = expand(in_data[3*IN_BITS-1 -: IN_BITS]);
    g_s    = expand(in_data[2*IN_BITS-1 -: IN_BITS]);
    b_s    = expand(in_data[IN_BITS-1:0]);
    ysum   = {2'b00, r_s} + {1'b0, g_s, 1'b0} + {2'b00, b_s};
    y_s    = ysum[OUT_BITS+1:2];
    rd0_s  = in_rng ? lb0[addr] : '0;
    rd1_s  = in_rng ? lb1[addr] : '0;
    mode_s = (in_valid && in_sof) ? mode : mode_q;
    col_d  = !in_valid ? col_q : in_eol ? '0 : in_rng ? col_s + 1'b1 : col_s;
    row_d  = !in_valid ? row_q : (in_eol && row_s != ROW_MAX) ? row_s + 1'b1 : row_s;
  end

  always_ff @(posedge clk)
    if (in_valid && in_rng) begin
      lb1[addr] <= rd0_s;
      lb0[addr] <= y_s;
    end

  logic [2:0] v_q, sof_q, eol_q;
  pix_t win_q [3][3];
  logic [1:0] mode1_q, mode2_q;
  logic bord1_q;
  pix_t r1_q, g1_q, b1_q, y1_q, r2_q, g2_q, b2_q, y2_q, mag2_q, or_q, og_q, ob_q;

  sgn_t gx, gy;
  logic [SW-1:0] ax, ay;
  logic [SW:0] msum, mshr;
  pix_t mag_s, mono, or_d, og_d, ob_d;

  // window rows: 0 = two lines up, 1 = one line up, 2 = current line; column 2 newest
  always_comb begin
    gx    = sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2])
          - sx(win_q[0][0]) - (sx(win_q[1][0]) <<< 1) - sx(win_q[2][0]);
    gy    = sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2])
          - sx(win_q[0][0]) - (sx(win_q[0][1]) <<< 1) - sx(win_q[0][2]);
    ax    = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay    = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    msum  = {1'b0, ax} + {1'b0, ay};
    mshr  = msum >> MAG_SHIFT;
    mag_s = bord1_q ? '0 : (|mshr[SW:OUT_BITS]) ? PIX_MAX : mshr[OUT_BITS-1:0];
    mono  = mode2_q == 2'd1 ? y2_q : mode2_q == 2'd2 ? mag2_q : (mag2_q >= thresh) ? PIX_MAX : '0;
    or_d  = !v_q[1] ? '0 : mode2_q == 2'd0 ? r2_q : mono;
    og_d  = !v_q[1] ? '0 : mode2_q == 2'd0 ? g2_q : mono;
    ob_d  = !v_q[1] ? '0 : mode2_q == 2'd0 ? b2_q : mono;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= '0;
      ovf_q   <= 1'b0;
      v_q     <= '0;
      sof_q   <= '0;
      eol_q   <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
      mode1_q <= '0;
      mode2_q <= '0;
      bord1_q <= 1'b1;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      y1_q    <= '0;
      r2_q    <= '0;
      g2_q    <= '0;
      b2_q    <= '0;
      y2_q    <= '0;
      mag2_q  <= '0;
      or_q    <= '0;
      og_q    <= '0;
      ob_q    <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_s;
      ovf_q   <= ovf_q | (in_valid & ~in_rng);
      v_q     <= {v_q[1:0], in_valid};
      sof_q   <= {sof_q[1:0], in_sof};
      eol_q   <= {eol_q[1:0], in_eol};
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= rd1_s;
        win_q[1][2] <= rd0_s;
        win_q[2][2] <= y_s;
      end
      mode1_q <= mode_s;
      bord1_q <= (col_s < COL_TWO) || (row_s < 11'd2);
      r1_q    <= r_s;
      g1_q    <= g_s;
      b1_q    <= b_s;
      y1_q    <= y_s;
      mode2_q <= mode1_q;
      r2_q    <= r1_q;
      g2_q    <= g1_q;
      b2_q    <= b1_q;
      y2_q    <= y1_q;
      mag2_q  <= mag_s;
      or_q    <= or_d;
      og_q    <= og_d;
      ob_q    <= ob_d;
    end
  end

  assign out_valid     = v_q[2];
  assign out_sof       = sof_q[2];
  assign out_eol       = eol_q[2];
  assign out_r         = or_q;
  assign out_g         = og_q;
  assign out_b         = ob_q;
  assign line_overflow = ovf_q;
endmodule

// File: tb/tb_video_filter_pipe.sv
// tb_video_filter_pipe: directed and random frames checked against an image-array model.
module tb_video_filter_pipe;
  localparam int IMG_W = 320;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
  logic [11:0] in_data = '0;
  logic [1:0] mode = '0;
  logic [7:0] thresh = '0;
  logic out_valid, out_sof, out_eol, line_overflow;
  logic [7:0] out_r, out_g, out_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  video_filter_pipe #(.IMG_W(IMG_W), .IN_BITS(4), .OUT_BITS(8), .MAG_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .in_data(in_data), .mode(mode), .thresh(thresh), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .line_overflow(line_overflow)
  );

  int img [16][336];
  int m_col, m_row, m_mode;
  bit m_ovf;
  logic [26:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_mode = 0;
    m_ovf = 1'b0;
    expq = {27'd0, 27'd0};
  endtask

  task automatic predict(input bit v, input bit sof, input bit eol, input logic [11:0] d,
                         output logic [26:0] e);
    int c, r, y, mag, gx, gy, o;
    int ch [3];
    if (!v) begin
      e = {1'b0, sof, eol, 24'd0};
      return;
    end
    c = sof ? 0 : m_col;
    r = sof ? 0 : m_row;
    if (sof) m_mode = int'(mode);
    for (int k = 0; k < 3; k++) ch[k] = int'(d[11-4*k -: 4]) * 17;
    y = (ch[0] + 2 * ch[1] + ch[2]) / 4;
    if (r < 16 && c < 336) img[r][c] = y;
    mag = 0;
    if (c >= 2 && r >= 2) begin
      gx = img[r-2][c] + 2 * img[r-1][c] + img[r][c] - img[r-2][c-2] - 2 * img[r-1][c-2] - img[r][c-2];
      gy = img[r][c-2] + 2 * img[r][c-1] + img[r][c] - img[r-2][c-2] - 2 * img[r-2][c-1] - img[r-2][c];
      mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 4;
      if (mag > 255) mag = 255;
    end
    if (c >= IMG_W) m_ovf = 1'b1;
    m_col = eol ? 0 : (c < IMG_W ? c + 1 : c);
    m_row = eol ? (r < 2047 ? r + 1 : r) : r;
    o = m_mode == 1 ? y : m_mode == 2 ? mag : (mag >= int'(thresh) ? 255 : 0);
    if (m_mode == 0) e = {1'b1, sof, eol, 8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
    else e = {1'b1, sof, eol, 8'(o), 8'(o), 8'(o)};
  endtask

  task automatic tick(input bit v, input bit sof, input bit eol, input logic [11:0] d, input string tag);
    logic [26:0] e;
    in_valid = v;
    in_sof = sof;
    in_eol = eol;
    in_data = d;
    predict(v, sof, eol, d, e);
    expq.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, {5'd0, out_valid, out_sof, out_eol, out_r, out_g, out_b}, {5'd0, expq.pop_front()});
    chk({tag, "_ovf"}, {31'd0, line_overflow}, {31'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, "idle");
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sof = 1'b0;
      in_eol = 1'b0;
      in_data = 12'($urandom);
      @(posedge clk);
      #1;
      chk("reset_out", {4'd0, out_valid, out_sof, out_eol, line_overflow, out_r, out_g, out_b}, 32'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // kind: 0 flat white, 1 vertical edge at col 4, 2 random
  task automatic frame(input int w, input int h, input int kind, input int gap, input int mid_mode,
                       input string tag);
    logic [11:0] d;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        while (gap > 0 && $urandom_range(0, 99) < gap) tick(1'b0, 1'b0, 1'b0, 12'h000, tag);
        d = kind == 0 ? 12'hFFF : kind == 1 ? (c < 4 ? 12'h000 : 12'hFFF) : 12'($urandom);
        tick(1'b1, r == 0 && c == 0, c == w - 1, d, tag);
        if (r == 0 && c == 0 && mid_mode >= 0) mode = 2'(mid_mode);
      end
  endtask

  initial begin
    reset_pulse();
    mode = 2'd2;
    tick(1'b1, 1'b0, 1'b0, 12'h123, "mode_after_reset");
    idle(3);
    mode = 2'd0;
    tick(1'b1, 1'b1, 1'b1, 12'hA53, "colour");
    idle(2);
    chk("colour_px", {7'd0, out_valid, out_r, out_g, out_b}, {7'd0, 1'b1, 8'hAA, 8'h55, 8'h33});
    idle(2);
    mode = 2'd1;
    frame(8, 4, 0, 0, 2, "gray");
    idle(3);
    frame(8, 4, 1, 0, -1, "sobel");
    idle(3);
    mode = 2'd3;
    thresh = 8'h80;
    frame(8, 4, 1, 0, -1, "thresh");
    idle(3);
    frame(8, 4, 1, 30, -1, "thresh_gaps");
    idle(3);
    for (int i = 0; i < 325; i++) begin
      tick(1'b1, i == 0, i == 324, 12'($urandom), "overflow");
      tick(1'b0, 1'b0, 1'b0, 12'h000, "overflow_gap");
    end
    idle(3);
    chk("ovf_sticky", {31'd0, line_overflow}, 32'd1);
    for (int f = 0; f < 12; f++) begin
      mode = 2'($urandom_range(0, 3));
      thresh = 8'($urandom);
      frame($urandom_range(3, 10), $urandom_range(3, 5), 2, 25, $urandom_range(0, 3), "random");
      idle(3);
    end
    chk("ovf_still", {31'd0, line_overflow}, 32'd1);
    mode = 2'd2;
    for (int i = 0; i < 5; i++) tick(1'b1, i == 0, 1'b0, 12'($urandom), "pre_reset");
    reset_pulse();
    tick(1'b1, 1'b0, 1'b0, 12'h5C7, "mode_after_reset2");
    idle(3);
    mode = 2'd2;
    frame(6, 4, 2, 10, -1, "post_reset");
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
